// File: rtl/ifu_pkg.sv
// Shared fetch-path types and helpers.
//   FQ_DEPTH_DEF / FETCH_W_DEF / VA_SIZE_DEF : default queue sizing
//   fetch_slot_t                             : one queued instruction
//   popcount_lanes()                         : set-bit count of up to 4 lanes
package ifu_pkg;

    localparam int unsigned FQ_DEPTH_DEF = 8;
    localparam int unsigned FETCH_W_DEF  = 2;
    localparam int unsigned VA_SIZE_DEF  = 48;

    // pc is sized for the widest supported VA; narrower PCs are zero-extended
    typedef struct packed {
        logic [VA_SIZE_DEF-1:0] pc;
        logic [31:0]            opcode;
        logic                   pr_taken;
    } fetch_slot_t;

    function automatic logic [2:0] popcount_lanes(input logic [3:0] lanes);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(lanes[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ifu_fq_compact.sv
// Lane compaction: maps a lane-valid mask to per-lane destination offsets
// (exclusive prefix popcount) and the total number of valid lanes.
//   i_vld   : per-lane valid, lane 0 oldest
//   o_off   : lane i offset at [i*OFF_W +: OFF_W] (meaningful only where i_vld[i])
//   o_total : popcount(i_vld)
module ifu_fq_compact #(
    parameter int unsigned FETCH_W = 2
) (
    input  logic [FETCH_W-1:0]                        i_vld,
    output logic [FETCH_W*($clog2(FETCH_W)+1)-1:0]    o_off,
    output logic [$clog2(FETCH_W):0]                  o_total
);

    localparam int unsigned OFF_W = $clog2(FETCH_W) + 1;

    logic [OFF_W-1:0] w_acc;

    // Running count of valid lanes below each lane
    always_comb begin
        w_acc = '0;
        o_off = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            o_off[i*OFF_W +: OFF_W] = w_acc;
            w_acc = w_acc + OFF_W'(i_vld[i]);
        end
        o_total = w_acc;
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue between icache fetch and decode.
// Accepts up to FETCH_W instructions per cycle (lane mask, holes allowed),
// stores them compacted in program order, presents up to ISSUE_W oldest.
//   clk, reset (async, active low), clear (redirect flush)
//   push_vld/push_pc/push_opcode/push_pr_taken : fetch-side lanes
//   free_cnt (registered), push_ok (combinational)
//   out_vld/out_pc/out_opcode/out_pr_taken     : decode-side slots, slot 0 oldest
//   pop_cnt                                     : slots consumed by decode
//   err_ovf / err_udf                           : sticky protocol error flags
// VA_SIZE must not exceed ifu_pkg::VA_SIZE_DEF.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned FETCH_W = FETCH_W_DEF,
    parameter int unsigned ISSUE_W = 1,
    parameter int unsigned DEPTH   = FQ_DEPTH_DEF,
    parameter int unsigned VA_SIZE = VA_SIZE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [FETCH_W-1:0]           push_vld,
    input  logic [FETCH_W*VA_SIZE-1:0]   push_pc,
    input  logic [FETCH_W*32-1:0]        push_opcode,
    input  logic [FETCH_W-1:0]           push_pr_taken,
    output logic [$clog2(DEPTH):0]       free_cnt,
    output logic                         push_ok,
    output logic [ISSUE_W-1:0]           out_vld,
    output logic [ISSUE_W*VA_SIZE-1:0]   out_pc,
    output logic [ISSUE_W*32-1:0]        out_opcode,
    output logic [ISSUE_W-1:0]           out_pr_taken,
    input  logic [$clog2(ISSUE_W):0]     pop_cnt,
    output logic                         err_ovf,
    output logic                         err_udf
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned OFF_W = $clog2(FETCH_W) + 1;
    localparam int unsigned POP_W = $clog2(ISSUE_W) + 1;

    logic [PW-1:0]            r_rd_ptr;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_free;
    logic                     r_err_ovf;
    logic                     r_err_udf;
    fetch_slot_t              r_mem [DEPTH];

    logic [FETCH_W*OFF_W-1:0] w_off;
    logic [OFF_W-1:0]         w_push_n;
    logic [PW-1:0]            w_count;
    logic                     w_push_req;
    logic                     w_push;
    logic [PW-1:0]            w_push_amt;
    logic [POP_W-1:0]         w_avail;
    logic                     w_pop_bad;
    logic [POP_W-1:0]         w_pop_n;

    ifu_fq_compact #(
        .FETCH_W (FETCH_W)
    ) u_compact (
        .i_vld   (push_vld),
        .o_off   (w_off),
        .o_total (w_push_n)
    );

    // Wrap-bit pointers make the difference the occupancy directly
    assign w_count    = r_wr_ptr - r_rd_ptr;

    // Space freed by a same-cycle pop is not usable until next cycle
    assign push_ok    = PW'(w_push_n) <= r_free;
    assign w_push_req = |push_vld;
    assign w_push     = push_ok & w_push_req & ~clear;
    assign w_push_amt = w_push ? PW'(w_push_n) : '0;

    assign w_avail    = POP_W'(popcount_lanes(4'(out_vld)));
    assign w_pop_bad  = pop_cnt > w_avail;
    assign w_pop_n    = (w_pop_bad | clear) ? '0 : pop_cnt;

    assign free_cnt   = r_free;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;

    // Read slots: slot k shows entry rd_ptr+k
    always_comb begin
        out_vld      = '0;
        out_pc       = '0;
        out_opcode   = '0;
        out_pr_taken = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_vld[k]                     = w_count > PW'(k);
            out_pc[k*VA_SIZE +: VA_SIZE]   = r_mem[AW'(r_rd_ptr[AW-1:0] + AW'(k))].pc[VA_SIZE-1:0];
            out_opcode[k*32 +: 32]         = r_mem[AW'(r_rd_ptr[AW-1:0] + AW'(k))].opcode;
            out_pr_taken[k]                = r_mem[AW'(r_rd_ptr[AW-1:0] + AW'(k))].pr_taken;
        end
    end

    // Control state: pointers, free count, sticky errors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_free    <= PW'(DEPTH);
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_free   <= PW'(DEPTH);
            end else begin
                r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
                r_wr_ptr <= r_wr_ptr + w_push_amt;
                r_free   <= r_free + PW'(w_pop_n) - w_push_amt;
            end
            if (w_push_req && !push_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (w_pop_bad) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // Array write: valid lanes land at consecutive entries from wr_ptr
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (push_vld[i]) begin
                    r_mem[AW'(r_wr_ptr[AW-1:0] + AW'(w_off[i*OFF_W +: OFF_W]))] <= '{
                        pc:       VA_SIZE_DEF'(push_pc[i*VA_SIZE +: VA_SIZE]),
                        opcode:   push_opcode[i*32 +: 32],
                        pr_taken: push_pr_taken[i]
                    };
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: instance A (2-in/1-out, depth 8) and
// instance B (4-in/2-out, depth 8) sharing clock and reset.
module tb_ifu_fetch_queue;

    logic         clk;
    logic         reset;

    logic         a_clear;
    logic [1:0]   a_push_vld;
    logic [95:0]  a_push_pc;
    logic [63:0]  a_push_opcode;
    logic [1:0]   a_push_pr_taken;
    logic [3:0]   a_free_cnt;
    logic         a_push_ok;
    logic [0:0]   a_out_vld;
    logic [47:0]  a_out_pc;
    logic [31:0]  a_out_opcode;
    logic [0:0]   a_out_pr_taken;
    logic [0:0]   a_pop_cnt;
    logic         a_err_ovf;
    logic         a_err_udf;

    logic         b_clear;
    logic [3:0]   b_push_vld;
    logic [191:0] b_push_pc;
    logic [127:0] b_push_opcode;
    logic [3:0]   b_push_pr_taken;
    logic [3:0]   b_free_cnt;
    logic         b_push_ok;
    logic [1:0]   b_out_vld;
    logic [95:0]  b_out_pc;
    logic [63:0]  b_out_opcode;
    logic [1:0]   b_out_pr_taken;
    logic [1:0]   b_pop_cnt;
    logic         b_err_ovf;
    logic         b_err_udf;

    int errors;
    int checks;

    ifu_fetch_queue #(.FETCH_W(2), .ISSUE_W(1), .DEPTH(8), .VA_SIZE(48)) dut_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .push_vld(a_push_vld), .push_pc(a_push_pc), .push_opcode(a_push_opcode),
        .push_pr_taken(a_push_pr_taken), .free_cnt(a_free_cnt), .push_ok(a_push_ok),
        .out_vld(a_out_vld), .out_pc(a_out_pc), .out_opcode(a_out_opcode),
        .out_pr_taken(a_out_pr_taken), .pop_cnt(a_pop_cnt),
        .err_ovf(a_err_ovf), .err_udf(a_err_udf)
    );

    ifu_fetch_queue #(.FETCH_W(4), .ISSUE_W(2), .DEPTH(8), .VA_SIZE(48)) dut_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .push_vld(b_push_vld), .push_pc(b_push_pc), .push_opcode(b_push_opcode),
        .push_pr_taken(b_push_pr_taken), .free_cnt(b_free_cnt), .push_ok(b_push_ok),
        .out_vld(b_out_vld), .out_pc(b_out_pc), .out_opcode(b_out_opcode),
        .out_pr_taken(b_out_pr_taken), .pop_cnt(b_pop_cnt),
        .err_ovf(b_err_ovf), .err_udf(b_err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane_op(input logic [47:0] pc);
        return pc[31:0] ^ 32'h1300_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic [1:0] vld, input logic [47:0] p0, input logic [47:0] p1,
                           input logic [0:0] pop);
        a_push_vld      = vld;
        a_push_pc       = {p1, p0};
        a_push_opcode   = {lane_op(p1), lane_op(p0)};
        a_push_pr_taken = {p1[2], p0[2]};
        a_pop_cnt       = pop;
    endtask

    task automatic b_drive(input logic [3:0] vld, input logic [47:0] p0, input logic [47:0] p1,
                           input logic [47:0] p2, input logic [47:0] p3, input logic [1:0] pop);
        b_push_vld      = vld;
        b_push_pc       = {p3, p2, p1, p0};
        b_push_opcode   = {lane_op(p3), lane_op(p2), lane_op(p1), lane_op(p0)};
        b_push_pr_taken = {p3[2], p2[2], p1[2], p0[2]};
        b_pop_cnt       = pop;
    endtask

    task automatic idle();
        a_clear = 1'b0; a_push_vld = '0; a_pop_cnt = '0;
        b_clear = 1'b0; b_push_vld = '0; b_pop_cnt = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        a_push_pc = '0; a_push_opcode = '0; a_push_pr_taken = '0;
        b_push_pc = '0; b_push_opcode = '0; b_push_pr_taken = '0;
        tick();
        tick();
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL rst_a_vld got=%0h exp=0", a_out_vld); end
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL rst_a_free got=%0d exp=8", a_free_cnt); end
        checks++; if (a_push_ok !== 1'b1) begin errors++; $display("FAIL rst_a_push_ok got=%0b exp=1", a_push_ok); end
        checks++; if ({a_err_ovf, a_err_udf} !== 2'b00) begin errors++; $display("FAIL rst_a_err got=%0b%0b exp=00", a_err_ovf, a_err_udf); end
        checks++; if (b_out_vld !== 2'b00) begin errors++; $display("FAIL rst_b_vld got=%0b exp=00", b_out_vld); end
        checks++; if (b_free_cnt !== 4'd8) begin errors++; $display("FAIL rst_b_free got=%0d exp=8", b_free_cnt); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_push_basic();
        a_drive(2'b11, 48'h100, 48'h104, 1'b0);
        tick();
        idle();
        checks++; if (a_out_vld !== 1'b1) begin errors++; $display("FAIL t1_vld got=%0b exp=1", a_out_vld); end
        checks++; if (a_out_pc !== 48'h100) begin errors++; $display("FAIL t1_pc got=%0h exp=100", a_out_pc); end
        checks++; if (a_out_opcode !== 32'h1300_0100) begin errors++; $display("FAIL t1_op got=%0h exp=13000100", a_out_opcode); end
        checks++; if (a_free_cnt !== 4'd6) begin errors++; $display("FAIL t1_free got=%0d exp=6", a_free_cnt); end
        a_pop_cnt = 1'b1;
        tick();
        idle();
        checks++; if (a_out_pc !== 48'h104) begin errors++; $display("FAIL t1_pc2 got=%0h exp=104", a_out_pc); end
        checks++; if (a_out_pr_taken !== 1'b1) begin errors++; $display("FAIL t1_prt got=%0b exp=1", a_out_pr_taken); end
        checks++; if (a_free_cnt !== 4'd7) begin errors++; $display("FAIL t1_free2 got=%0d exp=7", a_free_cnt); end
        a_pop_cnt = 1'b1;
        tick();
        idle();
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL t1_empty got=%0b exp=0", a_out_vld); end
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL t1_free3 got=%0d exp=8", a_free_cnt); end
    endtask

    task automatic test_hole_mask();
        b_drive(4'b1010, 48'hDEAD0, 48'h204, 48'hDEAD8, 48'h20C, 2'd0);
        #1;
        checks++; if (b_push_ok !== 1'b1) begin errors++; $display("FAIL t2_push_ok got=%0b exp=1", b_push_ok); end
        tick();
        idle();
        checks++; if (b_free_cnt !== 4'd6) begin errors++; $display("FAIL t2_free got=%0d exp=6", b_free_cnt); end
        checks++; if (b_out_vld !== 2'b11) begin errors++; $display("FAIL t2_vld got=%0b exp=11", b_out_vld); end
        checks++; if (b_out_pc[47:0] !== 48'h204) begin errors++; $display("FAIL t2_pc0 got=%0h exp=204", b_out_pc[47:0]); end
        checks++; if (b_out_pc[95:48] !== 48'h20C) begin errors++; $display("FAIL t2_pc1 got=%0h exp=20c", b_out_pc[95:48]); end
        b_pop_cnt = 2'd1;
        tick();
        idle();
        checks++; if (b_out_vld !== 2'b01) begin errors++; $display("FAIL t2_vld2 got=%0b exp=01", b_out_vld); end
        checks++; if (b_out_pc[47:0] !== 48'h20C) begin errors++; $display("FAIL t2_pop2 got=%0h exp=20c", b_out_pc[47:0]); end
        checks++; if (b_free_cnt !== 4'd7) begin errors++; $display("FAIL t2_free2 got=%0d exp=7", b_free_cnt); end
        b_pop_cnt = 2'd1;
        tick();
        idle();
        checks++; if (b_free_cnt !== 4'd8) begin errors++; $display("FAIL t2_free3 got=%0d exp=8", b_free_cnt); end
    endtask

    task automatic test_overflow();
        logic [47:0] e;
        a_drive(2'b11, 48'h300, 48'h304, 1'b0); tick();
        a_drive(2'b11, 48'h308, 48'h30C, 1'b0); tick();
        a_drive(2'b11, 48'h310, 48'h314, 1'b0); tick();
        a_drive(2'b01, 48'h318, 48'hBAD, 1'b0); tick();
        idle();
        checks++; if (a_free_cnt !== 4'd1) begin errors++; $display("FAIL t3_free1 got=%0d exp=1", a_free_cnt); end
        a_drive(2'b11, 48'h31C, 48'h320, 1'b0);
        #1;
        checks++; if (a_push_ok !== 1'b0) begin errors++; $display("FAIL t3_reject got=%0b exp=0", a_push_ok); end
        tick();
        idle();
        checks++; if (a_err_ovf !== 1'b1) begin errors++; $display("FAIL t3_err_ovf got=%0b exp=1", a_err_ovf); end
        checks++; if (a_free_cnt !== 4'd1) begin errors++; $display("FAIL t3_unchanged got=%0d exp=1", a_free_cnt); end
        checks++; if (a_out_pc !== 48'h300) begin errors++; $display("FAIL t3_head got=%0h exp=300", a_out_pc); end
        a_drive(2'b01, 48'h31C, 48'hBAD, 1'b0);
        #1;
        checks++; if (a_push_ok !== 1'b1) begin errors++; $display("FAIL t3_accept got=%0b exp=1", a_push_ok); end
        tick();
        idle();
        checks++; if (a_free_cnt !== 4'd0) begin errors++; $display("FAIL t3_full got=%0d exp=0", a_free_cnt); end
        // full with a pop still rejects a push
        a_drive(2'b01, 48'hBAD, 48'hBAD, 1'b1);
        #1;
        checks++; if (a_push_ok !== 1'b0) begin errors++; $display("FAIL t3_full_pop got=%0b exp=0", a_push_ok); end
        tick();
        idle();
        checks++; if (a_free_cnt !== 4'd1) begin errors++; $display("FAIL t3_free_after got=%0d exp=1", a_free_cnt); end
        e = 48'h304;
        for (int i = 0; i < 7; i++) begin
            checks++; if (a_out_pc !== e) begin errors++; $display("FAIL t3_drain%0d got=%0h exp=%0h", i, a_out_pc, e); end
            a_pop_cnt = 1'b1;
            tick();
            e = e + 48'd4;
        end
        idle();
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL t3_empty got=%0b exp=0", a_out_vld); end
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL t3_free_end got=%0d exp=8", a_free_cnt); end
    endtask

    task automatic test_wrap();
        logic [1:0]  masks [5];
        logic [47:0] q [$];
        logic [47:0] next_pc;
        logic [47:0] p0;
        logic [47:0] p1;
        logic [1:0]  m;
        logic        pop;
        int          n;
        masks   = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00};
        next_pc = 48'h400;
        for (int cyc = 0; cyc < 20; cyc++) begin
            checks++; if (int'(a_free_cnt) != 8 - q.size()) begin errors++; $display("FAIL t4_free c%0d got=%0d exp=%0d", cyc, a_free_cnt, 8 - q.size()); end
            checks++; if (a_out_vld !== (q.size() != 0)) begin errors++; $display("FAIL t4_vld c%0d got=%0b exp=%0b", cyc, a_out_vld, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (a_out_pc !== q[0]) begin errors++; $display("FAIL t4_pc c%0d got=%0h exp=%0h", cyc, a_out_pc, q[0]); end
            end
            m = masks[cyc % 5];
            n = int'(m[0]) + int'(m[1]);
            if (n > 8 - q.size()) m = 2'b00;
            p0 = 48'hEEE; p1 = 48'hEEE;
            if (m[0]) begin p0 = next_pc; next_pc = next_pc + 48'd4; end
            if (m[1]) begin p1 = next_pc; next_pc = next_pc + 48'd4; end
            pop = (q.size() != 0);
            a_drive(m, p0, p1, pop);
            tick();
            if (pop) void'(q.pop_front());
            if (m[0]) q.push_back(p0);
            if (m[1]) q.push_back(p1);
        end
        idle();
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            checks++; if (a_out_pc !== q[0]) begin errors++; $display("FAIL t4_drain%0d got=%0h exp=%0h", i, a_out_pc, q[0]); end
            a_pop_cnt = 1'b1;
            tick();
            void'(q.pop_front());
        end
        idle();
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL t4_free_end got=%0d exp=8", a_free_cnt); end
    endtask

    task automatic test_clear();
        a_drive(2'b11, 48'h500, 48'h504, 1'b0); tick();
        a_drive(2'b01, 48'h508, 48'hBAD, 1'b0); tick();
        idle();
        checks++; if (a_free_cnt !== 4'd5) begin errors++; $display("FAIL t5_free_pre got=%0d exp=5", a_free_cnt); end
        a_drive(2'b11, 48'h50C, 48'h510, 1'b1);
        a_clear = 1'b1;
        #1;
        checks++; if (a_out_vld !== 1'b1) begin errors++; $display("FAIL t5_vld_during got=%0b exp=1", a_out_vld); end
        tick();
        idle();
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL t5_vld_after got=%0b exp=0", a_out_vld); end
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL t5_free got=%0d exp=8", a_free_cnt); end
        checks++; if (a_err_ovf !== 1'b1) begin errors++; $display("FAIL t5_err_kept got=%0b exp=1", a_err_ovf); end
        checks++; if (a_err_udf !== 1'b0) begin errors++; $display("FAIL t5_udf got=%0b exp=0", a_err_udf); end
        a_drive(2'b01, 48'h600, 48'hBAD, 1'b0);
        tick();
        idle();
        checks++; if (a_out_pc !== 48'h600) begin errors++; $display("FAIL t5_repush got=%0h exp=600", a_out_pc); end
        checks++; if (a_free_cnt !== 4'd7) begin errors++; $display("FAIL t5_free2 got=%0d exp=7", a_free_cnt); end
        a_pop_cnt = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_issue2();
        b_drive(4'b0111, 48'h700, 48'h704, 48'h708, 48'hBAD, 2'd0);
        tick();
        idle();
        checks++; if (b_free_cnt !== 4'd5) begin errors++; $display("FAIL t6_free got=%0d exp=5", b_free_cnt); end
        checks++; if (b_out_pc[95:48] !== 48'h704) begin errors++; $display("FAIL t6_pc1 got=%0h exp=704", b_out_pc[95:48]); end
        b_pop_cnt = 2'd2;
        tick();
        idle();
        checks++; if (b_out_vld !== 2'b01) begin errors++; $display("FAIL t6_vld got=%0b exp=01", b_out_vld); end
        checks++; if (b_out_pc[47:0] !== 48'h708) begin errors++; $display("FAIL t6_remain got=%0h exp=708", b_out_pc[47:0]); end
        checks++; if (b_free_cnt !== 4'd7) begin errors++; $display("FAIL t6_free2 got=%0d exp=7", b_free_cnt); end
        b_pop_cnt = 2'd1;
        tick();
        idle();
        checks++; if (b_err_udf !== 1'b0) begin errors++; $display("FAIL t6_udf_clean got=%0b exp=0", b_err_udf); end
        // underflowing pop with a legal push: push lands, pop is dropped
        b_drive(4'b0001, 48'h800, 48'hBAD, 48'hBAD, 48'hBAD, 2'd1);
        tick();
        idle();
        checks++; if (b_err_udf !== 1'b1) begin errors++; $display("FAIL t6_udf got=%0b exp=1", b_err_udf); end
        checks++; if (b_free_cnt !== 4'd7) begin errors++; $display("FAIL t6_free3 got=%0d exp=7", b_free_cnt); end
        checks++; if (b_out_pc[47:0] !== 48'h800) begin errors++; $display("FAIL t6_push_kept got=%0h exp=800", b_out_pc[47:0]); end
        checks++; if (b_err_ovf !== 1'b0) begin errors++; $display("FAIL t6_ovf got=%0b exp=0", b_err_ovf); end
    endtask

    task automatic test_reset_mid();
        a_drive(2'b11, 48'h900, 48'h904, 1'b0);
        b_drive(4'b1111, 48'h900, 48'h904, 48'h908, 48'h90C, 2'd0);
        tick();
        reset = 1'b0;
        #1;
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL t7_a_vld got=%0b exp=0", a_out_vld); end
        checks++; if (a_free_cnt !== 4'd8) begin errors++; $display("FAIL t7_a_free got=%0d exp=8", a_free_cnt); end
        checks++; if (a_push_ok !== 1'b1) begin errors++; $display("FAIL t7_a_push_ok got=%0b exp=1", a_push_ok); end
        checks++; if ({a_err_ovf, a_err_udf} !== 2'b00) begin errors++; $display("FAIL t7_a_err got=%0b%0b exp=00", a_err_ovf, a_err_udf); end
        checks++; if (b_out_vld !== 2'b00) begin errors++; $display("FAIL t7_b_vld got=%0b exp=00", b_out_vld); end
        checks++; if (b_free_cnt !== 4'd8) begin errors++; $display("FAIL t7_b_free got=%0d exp=8", b_free_cnt); end
        checks++; if (b_err_udf !== 1'b0) begin errors++; $display("FAIL t7_b_udf got=%0b exp=0", b_err_udf); end
        idle();
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL t7_a_post got=%0b exp=0", a_out_vld); end
        checks++; if (b_free_cnt !== 4'd8) begin errors++; $display("FAIL t7_b_post got=%0d exp=8", b_free_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_push_basic();
        test_hole_mask();
        test_overflow();
        test_wrap();
        test_clear();
        test_issue2();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
